ram_dp_be: RTL

RAM_DP_BE -- requirements
Module: ram_dp_be

---
 rtl/ram_pkg.sv | 12 +
 rtl/ram_rd_pipe.sv | 49 ++++
 rtl/ram_dp_be.sv | 90 +++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ram_pkg - shared constants and helpers for the byte-enabled dual-port RAM.
//   BYTE_W         : width of one byte lane (8)
//   be_width(dw)   : number of byte lanes for a word of dw bits
package ram_pkg;

    localparam int BYTE_W = 8;

    function automatic int be_width(input int dw);
        return dw / BYTE_W;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe - read data/valid pipeline behind the RAM output register.
//   Parameters: data_width, latency (number of stages, 1 or 2)
//   i_clk   : clock
//   i_rst   : asynchronous active-high reset, clears every stage
//   i_valid : a read word is present on i_data
//   i_data  : read word from the storage output register
//   o_valid : one-cycle pulse per completed read
//   o_data  : read data, holds the last valid value while o_valid=0
module ram_rd_pipe #(
    parameter int data_width = 32,
    parameter int latency    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [data_width-1:0] i_data,
    output logic                  o_valid,
    output logic [data_width-1:0] o_data
);

    logic [latency-1:0]    r_vld;
    logic [data_width-1:0] r_data [latency];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld <= '0;
            for (int i = 0; i < latency; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            // Data stages only load on a valid word so the output holds
            // the last returned value between reads.
            if (i_valid) begin
                r_data[0] <= i_data;
            end
            for (int i = 1; i < latency; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign o_valid = r_vld[latency-1];
    assign o_data  = r_data[latency-1];

endmodule

// File: rtl/ram_dp_be.sv
// ram_dp_be - simple dual-port RAM (one read, one write port) with per-byte
// write enables and a pipelined, registered read path.
//   Parameters: addr_width (depth 2**addr_width), data_width (multiple of 8),
//               read_latency (1 or 2 cycles from request edge to data)
//   CLK       : clock
//   RESET     : asynchronous active-high reset (pipeline only, not memory)
//   ADRR_R    : read address        ENABLE_R : read request
//   Q_R       : read data           VALID_R  : read data valid pulse
//   ADRR_W    : write address       ENABLE_W : write request
//   BYTE_EN_W : byte lane mask      Q_W      : write data
// Build option: define RAM_DP_BE_BYPASS_EN for write-first behaviour on a
// same-address read/write collision; default is read-first.
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int addr_width   = 10,
    parameter int data_width   = 32,
    parameter int read_latency = 1
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [addr_width-1:0]             ADRR_R,
    input  logic                              ENABLE_R,
    output logic [data_width-1:0]             Q_R,
    output logic                              VALID_R,
    input  logic [addr_width-1:0]             ADRR_W,
    input  logic                              ENABLE_W,
    input  logic [be_width(data_width)-1:0]   BYTE_EN_W,
    input  logic [data_width-1:0]             Q_W
);

    localparam int BE_W = be_width(data_width);

    // Storage and its output register carry no reset so they map to block RAM.
    logic [data_width-1:0] r_mem [2**addr_width];
    logic [data_width-1:0] r_rd_word;
    logic                  r_rd_req;
    logic [data_width-1:0] w_rd_word;

`ifdef RAM_DP_BE_BYPASS_EN
    // Write-first: enabled bytes of a same-address write replace the old ones.
    always_comb begin
        w_rd_word = r_mem[ADRR_R];
        if (ENABLE_W && (ADRR_W == ADRR_R)) begin
            for (int i = 0; i < BE_W; i++) begin
                if (BYTE_EN_W[i]) begin
                    w_rd_word[i*BYTE_W +: BYTE_W] = Q_W[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end
`else
    assign w_rd_word = r_mem[ADRR_R];
`endif

    always_ff @(posedge CLK) begin
        if (ENABLE_W && !RESET) begin
            for (int i = 0; i < BE_W; i++) begin
                if (BYTE_EN_W[i]) begin
                    r_mem[ADRR_W][i*BYTE_W +: BYTE_W] <= Q_W[i*BYTE_W +: BYTE_W];
                end
            end
        end
        // Word is captured at the request edge; later writes cannot alter it.
        if (ENABLE_R) begin
            r_rd_word <= w_rd_word;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd_req <= 1'b0;
        end else begin
            r_rd_req <= ENABLE_R;
        end
    end

    ram_rd_pipe #(
        .data_width (data_width),
        .latency    (read_latency)
    ) u_rd_pipe (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_valid (r_rd_req),
        .i_data  (r_rd_word),
        .o_valid (VALID_R),
        .o_data  (Q_R)
    );

endmodule
